// File: rtl/car_ctl.sv
// rtl/car_ctl.sv - sprite car controller: per-frame accelerate, steer and move sequence with wall clamping
// Optional build macro CAR_CTL_FRICTION_EN: coasting speed decays by one every fourth frame.
module car_ctl #(
  parameter int X_INIT    = 336,
  parameter int Y_INIT    = 236,
  parameter int X_MAX     = 672,
  parameter int Y_MAX     = 472,
  parameter int SPEED_MAX = 8
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_left,
  input  logic        key_right,
  output logic [10:0] xpos,
  output logic [10:0] ypos,
  output logic [1:0]  rotation,
  output logic [3:0]  speed,
  output logic        update
);

  typedef enum logic [1:0] {IDLE, ACCEL, STEER, MOVE} state_t;

  localparam logic [3:0]         SpdMax = 4'(SPEED_MAX);
  localparam logic signed [11:0] XMax   = 12'(X_MAX);
  localparam logic signed [11:0] YMax   = 12'(Y_MAX);

  state_t             state_q, state_d;
  logic               vsync_prev_q, left_prev_q, right_prev_q;
  logic               pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic [10:0]        xpos_q, xpos_d, ypos_q, ypos_d;
  logic [1:0]         rot_q, rot_d;
  logic [3:0]         speed_q, speed_d;
  logic               moved_q, update_q;
  logic               tick, left_edge, right_edge, friction;
  logic signed [11:0] step, x_try, y_try;

  assign tick       = vsync_in & ~vsync_prev_q;
  assign left_edge  = key_left & ~left_prev_q;
  assign right_edge = key_right & ~right_prev_q;

`ifdef CAR_CTL_FRICTION_EN
  logic [1:0] frame_cnt_q;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= 2'd0;
    end else if (tick) begin
      frame_cnt_q <= frame_cnt_q + 2'd1;
    end
  end

  assign friction = (frame_cnt_q == 2'd3);
`else
  assign friction = 1'b0;
`endif

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      vsync_prev_q <= 1'b0;
      left_prev_q  <= 1'b0;
      right_prev_q <= 1'b0;
      pend_l_q     <= 1'b0;
      pend_r_q     <= 1'b0;
      xpos_q       <= 11'(X_INIT);
      ypos_q       <= 11'(Y_INIT);
      rot_q        <= 2'b00;
      speed_q      <= 4'd0;
      moved_q      <= 1'b0;
      update_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_prev_q <= vsync_in;
      left_prev_q  <= key_left;
      right_prev_q <= key_right;
      pend_l_q     <= pend_l_d;
      pend_r_q     <= pend_r_d;
      xpos_q       <= xpos_d;
      ypos_q       <= ypos_d;
      rot_q        <= rot_d;
      speed_q      <= speed_d;
      // Position lands on the MOVE edge; the pulse follows one edge later.
      moved_q      <= (state_q == MOVE);
      update_q     <= moved_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_l_d = pend_l_q | left_edge;
    pend_r_d = pend_r_q | right_edge;
    xpos_d   = xpos_q;
    ypos_d   = ypos_q;
    rot_d    = rot_q;
    speed_d  = speed_q;
    step     = signed'({8'd0, speed_q});
    x_try    = signed'({1'b0, xpos_q});
    y_try    = signed'({1'b0, ypos_q});
    case (state_q)
      IDLE: begin
        if (tick) state_d = ACCEL;
      end
      ACCEL: begin
        state_d = STEER;
        if (key_up) begin
          if (speed_q < SpdMax) speed_d = speed_q + 4'd1;
        end else if (key_down) begin
          if (speed_q != 4'd0) speed_d = speed_q - 4'd1;
        end else if (friction && speed_q != 4'd0) begin
          speed_d = speed_q - 4'd1;
        end
      end
      STEER: begin
        state_d  = MOVE;
        // Edges arriving now belong to the next frame.
        pend_l_d = left_edge;
        pend_r_d = right_edge;
        if (pend_l_q && !pend_r_q)      rot_d = rot_q - 2'd1;
        else if (pend_r_q && !pend_l_q) rot_d = rot_q + 2'd1;
      end
      MOVE: begin
        state_d = IDLE;
        case (rot_q)
          2'b00:   y_try = y_try - step;
          2'b01:   x_try = x_try + step;
          2'b10:   y_try = y_try + step;
          default: x_try = x_try - step;
        endcase
        if (x_try < 12'sd0) begin
          xpos_d  = 11'd0;
          speed_d = 4'd0;
        end else if (x_try > XMax) begin
          xpos_d  = 11'(X_MAX);
          speed_d = 4'd0;
        end else begin
          xpos_d = x_try[10:0];
        end
        if (y_try < 12'sd0) begin
          ypos_d  = 11'd0;
          speed_d = 4'd0;
        end else if (y_try > YMax) begin
          ypos_d  = 11'(Y_MAX);
          speed_d = 4'd0;
        end else begin
          ypos_d = y_try[10:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign xpos     = xpos_q;
  assign ypos     = ypos_q;
  assign rotation = rot_q;
  assign speed    = speed_q;
  assign update   = update_q;

endmodule
